// File: rtl/reservation_station.sv
// ============================================================================
//  Module   : reservation_station
//  Brief    : Age-ordered reservation station with dual-CDB wakeup/bypass.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reservation_station #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int TAGW  = 6,
    parameter int OPW   = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [OPW-1:0]            issue_op,
    input  logic [XLEN-1:0]           issue_address,
    input  logic [XLEN-1:0]           issue_immediate,
    input  logic [TAGW-1:0]           issue_rd,
    input  logic [TAGW-1:0]           issue_rs_1,
    input  logic [TAGW-1:0]           issue_rs_2,
    input  logic [XLEN-1:0]           issue_data_1,
    input  logic [XLEN-1:0]           issue_data_2,
    input  logic                      issue_valid_1,
    input  logic                      issue_valid_2,
    input  logic [1:0]                cdb_valid,
    input  logic [1:0][TAGW-1:0]      cdb_rrn,
    input  logic [1:0][XLEN-1:0]      cdb_data,
    output logic                      dispatch_valid,
    input  logic                      dispatch_ready,
    output logic [OPW-1:0]            dispatch_op,
    output logic [XLEN-1:0]           dispatch_address,
    output logic [XLEN-1:0]           dispatch_immediate,
    output logic [TAGW-1:0]           dispatch_rd,
    output logic [XLEN-1:0]           dispatch_data_1,
    output logic [XLEN-1:0]           dispatch_data_2,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   c_age_max = AW'(DEPTH - 1);

    logic              r_busy    [DEPTH];
    logic [OPW-1:0]    r_op      [DEPTH];
    logic [XLEN-1:0]   r_address [DEPTH];
    logic [XLEN-1:0]   r_imm     [DEPTH];
    logic [TAGW-1:0]   r_rd      [DEPTH];
    logic [TAGW-1:0]   r_rs_1    [DEPTH];
    logic [TAGW-1:0]   r_rs_2    [DEPTH];
    logic [XLEN-1:0]   r_data_1  [DEPTH];
    logic [XLEN-1:0]   r_data_2  [DEPTH];
    logic              r_valid_1 [DEPTH];
    logic              r_valid_2 [DEPTH];
    logic [AW-1:0]     r_age     [DEPTH];
    logic [AW:0]       r_occ;

    logic [DEPTH-1:0]  w_ready;
    logic              w_free_found;
    logic [AW-1:0]     w_free_idx;
    logic              w_sel_found;
    logic [AW-1:0]     w_sel_idx;
    logic [AW-1:0]     w_sel_age;
    logic              w_issue_acc;
    logic              w_disp_acc;

    // Returns {valid, data}; a still-pending operand picks up a matching CDB, bus 0 first.
    function automatic logic [XLEN:0] f_capture(
        input logic                 valid,
        input logic [XLEN-1:0]      data,
        input logic [TAGW-1:0]      tag,
        input logic [1:0]           cv,
        input logic [1:0][TAGW-1:0] ct,
        input logic [1:0][XLEN-1:0] cd
    );
        logic [XLEN:0] res;
        res = {valid, data};
        if (!valid) begin
            if (cv[0] && (ct[0] == tag))
                res = {1'b1, cd[0]};
            else if (cv[1] && (ct[1] == tag))
                res = {1'b1, cd[1]};
        end
        return res;
    endfunction

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_ready
            assign w_ready[g] = r_busy[g] & r_valid_1[g] & r_valid_2[g];
        end
    endgenerate

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = AW'(i);
            end
        end
    end

    // Oldest ready entry wins; strict '>' keeps ties on the lowest index.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i] && (!w_sel_found || (r_age[i] > w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = AW'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    assign issue_ready        = (r_occ < c_depth) && !flush;
    assign dispatch_valid     = w_sel_found && !flush;
    assign w_issue_acc        = issue_valid && issue_ready;
    assign w_disp_acc         = dispatch_valid && dispatch_ready;
    assign occupancy          = r_occ;

    assign dispatch_op        = r_op[w_sel_idx];
    assign dispatch_address   = r_address[w_sel_idx];
    assign dispatch_immediate = r_imm[w_sel_idx];
    assign dispatch_rd        = r_rd[w_sel_idx];
    assign dispatch_data_1    = r_data_1[w_sel_idx];
    assign dispatch_data_2    = r_data_2[w_sel_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]    <= 1'b0;
                r_op[i]      <= '0;
                r_address[i] <= '0;
                r_imm[i]     <= '0;
                r_rd[i]      <= '0;
                r_rs_1[i]    <= '0;
                r_rs_2[i]    <= '0;
                r_data_1[i]  <= '0;
                r_data_2[i]  <= '0;
                r_valid_1[i] <= 1'b0;
                r_valid_2[i] <= 1'b0;
                r_age[i]     <= '0;
            end
            r_occ <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_age[i]  <= '0;
            end
            r_occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue_acc && (AW'(i) == w_free_idx)) begin
                    r_busy[i]    <= 1'b1;
                    r_op[i]      <= issue_op;
                    r_address[i] <= issue_address;
                    r_imm[i]     <= issue_immediate;
                    r_rd[i]      <= issue_rd;
                    r_rs_1[i]    <= issue_rs_1;
                    r_rs_2[i]    <= issue_rs_2;
                    r_age[i]     <= '0;
                    {r_valid_1[i], r_data_1[i]} <= f_capture(issue_valid_1, issue_data_1,
                                                             issue_rs_1, cdb_valid, cdb_rrn, cdb_data);
                    {r_valid_2[i], r_data_2[i]} <= f_capture(issue_valid_2, issue_data_2,
                                                             issue_rs_2, cdb_valid, cdb_rrn, cdb_data);
                end else if (r_busy[i]) begin
                    if (w_disp_acc && (AW'(i) == w_sel_idx))
                        r_busy[i] <= 1'b0;
                    if (w_issue_acc && (r_age[i] != c_age_max))
                        r_age[i] <= r_age[i] + AW'(1);
                    {r_valid_1[i], r_data_1[i]} <= f_capture(r_valid_1[i], r_data_1[i],
                                                             r_rs_1[i], cdb_valid, cdb_rrn, cdb_data);
                    {r_valid_2[i], r_data_2[i]} <= f_capture(r_valid_2[i], r_data_2[i],
                                                             r_rs_2[i], cdb_valid, cdb_rrn, cdb_data);
                end
            end
            r_occ <= r_occ + (AW+1)'(w_issue_acc) - (AW+1)'(w_disp_acc);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// ============================================================================
//  Module   : tb_reservation_station
//  Brief    : Scoreboard bench for reservation_station (issue, wakeup, select).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reservation_station;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [7:0]        issue_op;
    logic [31:0]       issue_address;
    logic [31:0]       issue_immediate;
    logic [5:0]        issue_rd;
    logic [5:0]        issue_rs_1;
    logic [5:0]        issue_rs_2;
    logic [31:0]       issue_data_1;
    logic [31:0]       issue_data_2;
    logic              issue_valid_1;
    logic              issue_valid_2;
    logic [1:0]        cdb_valid;
    logic [1:0][5:0]   cdb_rrn;
    logic [1:0][31:0]  cdb_data;
    logic              dispatch_valid;
    logic              dispatch_ready;
    logic [7:0]        dispatch_op;
    logic [31:0]       dispatch_address;
    logic [31:0]       dispatch_immediate;
    logic [5:0]        dispatch_rd;
    logic [31:0]       dispatch_data_1;
    logic [31:0]       dispatch_data_2;
    logic [3:0]        occupancy;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] imm;
        logic [5:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t sb[$];
    exp_t r_exp;
    int   checks = 0;
    int   errors = 0;

    reservation_station #(.DEPTH(8), .XLEN(32), .TAGW(6), .OPW(8)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .flush              (flush),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_op           (issue_op),
        .issue_address      (issue_address),
        .issue_immediate    (issue_immediate),
        .issue_rd           (issue_rd),
        .issue_rs_1         (issue_rs_1),
        .issue_rs_2         (issue_rs_2),
        .issue_data_1       (issue_data_1),
        .issue_data_2       (issue_data_2),
        .issue_valid_1      (issue_valid_1),
        .issue_valid_2      (issue_valid_2),
        .cdb_valid          (cdb_valid),
        .cdb_rrn            (cdb_rrn),
        .cdb_data           (cdb_data),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_op        (dispatch_op),
        .dispatch_address   (dispatch_address),
        .dispatch_immediate (dispatch_immediate),
        .dispatch_rd        (dispatch_rd),
        .dispatch_data_1    (dispatch_data_1),
        .dispatch_data_2    (dispatch_data_2),
        .occupancy          (occupancy)
    );

    always #5 clock = ~clock;

    // Inputs only move just after the rising edge, so the falling edge sees the handshake.
    always @(negedge clock) begin
        if (reset_n && dispatch_valid && dispatch_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dispatch_unexpected: got rd=%0d op=%h, expected no dispatch", dispatch_rd, dispatch_op);
            end else begin
                r_exp = sb.pop_front();
                if ({dispatch_op, dispatch_address, dispatch_immediate, dispatch_rd,
                     dispatch_data_1, dispatch_data_2} !== r_exp) begin
                    errors++;
                    $display("FAIL dispatch_fields: got op=%h addr=%h imm=%h rd=%0d d1=%h d2=%h, expected op=%h addr=%h imm=%h rd=%0d d1=%h d2=%h",
                             dispatch_op, dispatch_address, dispatch_immediate, dispatch_rd,
                             dispatch_data_1, dispatch_data_2,
                             r_exp.op, r_exp.addr, r_exp.imm, r_exp.rd, r_exp.d1, r_exp.d2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic [7:0] op, input logic [5:0] rd,
                               input logic [5:0] rs1, input logic [5:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic v1, input logic v2);
        issue_valid     = 1'b1;
        issue_op        = op;
        issue_rd        = rd;
        issue_address   = 32'h1000 + {24'h0, rd, 2'b00};
        issue_immediate = {26'h0, rd} ^ 32'hF0;
        issue_rs_1      = rs1;
        issue_rs_2      = rs2;
        issue_data_1    = d1;
        issue_data_2    = d2;
        issue_valid_1   = v1;
        issue_valid_2   = v2;
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [5:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        e.op   = op;
        e.rd   = rd;
        e.addr = 32'h1000 + {24'h0, rd, 2'b00};
        e.imm  = {26'h0, rd} ^ 32'hF0;
        e.d1   = d1;
        e.d2   = d2;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; dispatch_ready = 1'b0;
        issue_op = '0; issue_address = '0; issue_immediate = '0; issue_rd = '0;
        issue_rs_1 = '0; issue_rs_2 = '0; issue_data_1 = '0; issue_data_2 = '0;
        issue_valid_1 = 1'b0; issue_valid_2 = 1'b0;
        cdb_valid = '0; cdb_rrn = '0; cdb_data = '0;
        #1;
        checks++;
        if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++;
        if (dispatch_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", dispatch_valid); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_iready: got %b expected 1", issue_ready); end
    endtask

    task automatic test_basic();
        drive_issue(8'h11, 6'd5, 6'd0, 6'd0, 32'hA, 32'hB, 1'b1, 1'b1);
        push_exp(8'h11, 6'd5, 32'hA, 32'hB);
        dispatch_ready = 1'b1;
        #1;
        checks++;
        if (dispatch_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got dvalid=%b expected 0", dispatch_valid); end
        tick();
        issue_valid = 1'b0;
        #1;
        checks++;
        if ({dispatch_valid, dispatch_rd, dispatch_data_1, occupancy} !== {1'b1, 6'd5, 32'hA, 4'd1}) begin
            errors++;
            $display("FAIL basic_dispatch: got v=%b rd=%0d d1=%h occ=%0d expected v=1 rd=5 d1=a occ=1",
                     dispatch_valid, dispatch_rd, dispatch_data_1, occupancy);
        end
        tick();
        dispatch_ready = 1'b0;
        #1;
        checks++;
        if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_wakeup();
        drive_issue(8'h22, 6'd12, 6'd9, 6'd0, 32'h0, 32'h55, 1'b0, 1'b1);
        push_exp(8'h22, 6'd12, 32'h1234, 32'h55);
        dispatch_ready = 1'b1;
        tick();
        issue_valid = 1'b0;
        #1;
        checks++;
        if (dispatch_valid !== 1'b0) begin errors++; $display("FAIL wake_wait: got dvalid=%b expected 0", dispatch_valid); end
        tick();
        cdb_valid = 2'b10; cdb_rrn[1] = 6'd9; cdb_data[1] = 32'h1234;
        #1;
        checks++;
        if (dispatch_valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle: got dvalid=%b expected 0", dispatch_valid); end
        tick();
        cdb_valid = 2'b00;
        #1;
        checks++;
        if ({dispatch_valid, dispatch_data_1} !== {1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL wake_dispatch: got v=%b d1=%h expected v=1 d1=1234", dispatch_valid, dispatch_data_1);
        end
        tick();
        // Both buses match a pending operand; the already-valid one must stay put.
        drive_issue(8'h23, 6'd13, 6'd20, 6'd20, 32'h0, 32'h77, 1'b0, 1'b1);
        push_exp(8'h23, 6'd13, 32'hAA, 32'h77);
        tick();
        issue_valid = 1'b0;
        cdb_valid = 2'b11; cdb_rrn[0] = 6'd20; cdb_rrn[1] = 6'd20;
        cdb_data[0] = 32'hAA; cdb_data[1] = 32'hBB;
        tick();
        cdb_valid = 2'b00;
        #1;
        checks++;
        if ({dispatch_valid, dispatch_data_1, dispatch_data_2} !== {1'b1, 32'hAA, 32'h77}) begin
            errors++;
            $display("FAIL wake_priority: got v=%b d1=%h d2=%h expected v=1 d1=aa d2=77",
                     dispatch_valid, dispatch_data_1, dispatch_data_2);
        end
        tick();
        dispatch_ready = 1'b0;
        #1;
        checks++;
        if (occupancy !== 4'd0) begin errors++; $display("FAIL wake_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_bypass();
        drive_issue(8'h33, 6'd14, 6'd0, 6'd7, 32'h3, 32'h0, 1'b1, 1'b0);
        cdb_valid = 2'b11; cdb_rrn[0] = 6'd7; cdb_rrn[1] = 6'd7;
        cdb_data[0] = 32'h1; cdb_data[1] = 32'h2;
        push_exp(8'h33, 6'd14, 32'h3, 32'h1);
        dispatch_ready = 1'b1;
        tick();
        issue_valid = 1'b0; cdb_valid = 2'b00;
        #1;
        checks++;
        if ({dispatch_valid, dispatch_data_2} !== {1'b1, 32'h1}) begin
            errors++;
            $display("FAIL bypass: got v=%b d2=%h expected v=1 d2=1", dispatch_valid, dispatch_data_2);
        end
        tick();
        dispatch_ready = 1'b0;
    endtask

    task automatic test_full_and_back_to_back();
        dispatch_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_issue(8'h30 + 8'(i), 6'(i + 1), 6'd0, 6'd0, 32'h100 + i, 32'h200 + i, 1'b1, 1'b1);
            push_exp(8'h30 + 8'(i), 6'(i + 1), 32'h100 + i, 32'h200 + i);
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, issue_ready); end
            tick();
        end
        issue_valid = 1'b0;
        #1;
        checks++;
        if ({occupancy, issue_ready, dispatch_rd} !== {4'd8, 1'b0, 6'd1}) begin
            errors++;
            $display("FAIL full_state: got occ=%0d iready=%b rd=%0d expected occ=8 iready=0 rd=1",
                     occupancy, issue_ready, dispatch_rd);
        end
        // Dispatching while full must not open a slot for a same-cycle issue.
        drive_issue(8'h3F, 6'd30, 6'd0, 6'd0, 32'h1, 32'h2, 1'b1, 1'b1);
        dispatch_ready = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got iready=%b expected 0", issue_ready); end
        tick();
        issue_valid = 1'b0; dispatch_ready = 1'b0;
        #1;
        checks++;
        if ({occupancy, issue_ready, dispatch_rd} !== {4'd7, 1'b1, 6'd2}) begin
            errors++;
            $display("FAIL after_one: got occ=%0d iready=%b rd=%0d expected occ=7 iready=1 rd=2",
                     occupancy, issue_ready, dispatch_rd);
        end
        drive_issue(8'h40, 6'd9, 6'd0, 6'd0, 32'h900, 32'h901, 1'b1, 1'b1);
        push_exp(8'h40, 6'd9, 32'h900, 32'h901);
        dispatch_ready = 1'b1;
        tick();
        issue_valid = 1'b0;
        #1;
        checks++;
        if (occupancy !== 4'd7) begin errors++; $display("FAIL b2b_net: got occ=%0d expected 7", occupancy); end
        for (int k = 0; k < 20 && occupancy != 4'd0; k++) tick();
        dispatch_ready = 1'b0;
        checks++;
        if ({occupancy, 32'(sb.size())} !== {4'd0, 32'd0}) begin
            errors++;
            $display("FAIL drain: got occ=%0d pending=%0d expected occ=0 pending=0", occupancy, sb.size());
        end
    endtask

    task automatic test_flush();
        dispatch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_issue(8'h50, 6'(i + 40), 6'd0, 6'd0, 32'h5, 32'h6, 1'b1, 1'b1);
            tick();
        end
        issue_valid = 1'b0;
        #1;
        checks++;
        if ({dispatch_valid, occupancy} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL flush_pre: got v=%b occ=%0d expected v=1 occ=3", dispatch_valid, occupancy);
        end
        flush = 1'b1;
        drive_issue(8'h51, 6'd50, 6'd0, 6'd0, 32'h5, 32'h6, 1'b1, 1'b1);
        dispatch_ready = 1'b1;
        #1;
        checks++;
        if ({dispatch_valid, issue_ready} !== 2'b00) begin
            errors++;
            $display("FAIL flush_cycle: got dvalid=%b iready=%b expected 0 0", dispatch_valid, issue_ready);
        end
        tick();
        flush = 1'b0; issue_valid = 1'b0; dispatch_ready = 1'b0;
        #1;
        checks++;
        if ({dispatch_valid, occupancy} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_after: got v=%b occ=%0d expected v=0 occ=0", dispatch_valid, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        dispatch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(8'h60, 6'(i + 50), 6'd0, 6'd0, 32'h7, 32'h8, 1'b1, 1'b1);
            tick();
        end
        issue_valid = 1'b0;
        #1;
        checks++;
        if (occupancy !== 4'd4) begin errors++; $display("FAIL rstmid_pre: got occ=%0d expected 4", occupancy); end
        reset_n = 1'b0;
        dispatch_ready = 1'b1;
        #1;
        checks++;
        if ({dispatch_valid, occupancy} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rstmid_now: got v=%b occ=%0d expected v=0 occ=0", dispatch_valid, occupancy);
        end
        tick();
        reset_n = 1'b1; dispatch_ready = 1'b0;
        tick();
        checks++;
        if ({dispatch_valid, occupancy, issue_ready} !== {1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_after: got v=%b occ=%0d iready=%b expected v=0 occ=0 iready=1",
                     dispatch_valid, occupancy, issue_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full_and_back_to_back();
        test_flush();
        test_reset_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
